// File: rtl/cost_table_server.sv
// 8x8 table of 7-bit worker/job costs, loaded over a valid/ready stream and read combinationally.
// Define COST_TABLE_CHECK_EN to build the round checker (sum and permutation legality per 8 probes).
module cost_table_server (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LdValid,
  input  logic [6:0]  LdData,
  output logic        LdReady,
  output logic        Loaded,
  input  logic        Reload,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  input  logic        Probe,
  output logic        RoundDone,
  output logic [9:0]  RoundSum,
  output logic        PermErr,
  output logic [15:0] RoundCount
);

  typedef enum logic {LOAD, SERVE} state_e;

  state_e     state_q, state_d;
  logic [5:0] ptr_q, ptr_d;
  logic       ld_ready_q, ld_ready_d;
  logic       loaded_q, loaded_d;
  logic [6:0] table_q [64];
  logic       ld_fire;
  logic       reload_fire;

  assign ld_fire     = (state_q == LOAD) && LdValid && ld_ready_q;
  assign reload_fire = (state_q == SERVE) && Reload;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ld_ready_d = ld_ready_q;
    loaded_d   = loaded_q;
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          ptr_d = ptr_q + 6'd1;
          if (ptr_q == 6'd63) begin
            state_d    = SERVE;
            ld_ready_d = 1'b0;
            loaded_d   = 1'b1;
          end
        end
      end
      SERVE: begin
        if (Reload) begin
          state_d    = LOAD;
          ptr_d      = '0;
          ld_ready_d = 1'b1;
          loaded_d   = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      ld_ready_q <= 1'b1;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_ready_q <= ld_ready_d;
      loaded_q   <= loaded_d;
    end
  end

  // Table storage survives reset; only accepted load words write it.
  always_ff @(posedge CLK) begin
    if (ld_fire) table_q[ptr_q] <= LdData;
  end

  assign LdReady = ld_ready_q;
  assign Loaded  = loaded_q;
  assign Cost    = loaded_q ? table_q[{W, J}] : '0;

`ifdef COST_TABLE_CHECK_EN
  logic [9:0]  acc_q, acc_d;
  logic [7:0]  used_q, used_d;
  logic [2:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        round_done_q, round_done_d;
  logic [9:0]  round_sum_q, round_sum_d;
  logic        perm_err_q, perm_err_d;
  logic [15:0] round_count_q, round_count_d;
  logic        probe_fire;
  logic        probe_err;

  // Reload takes priority, so a coincident probe is dropped entirely.
  assign probe_fire = (state_q == SERVE) && Probe && !Reload;
  assign probe_err  = used_q[J] || (W != idx_q);

  always_comb begin
    acc_d         = acc_q;
    used_d        = used_q;
    idx_d         = idx_q;
    err_d         = err_q;
    round_done_d  = 1'b0;
    round_sum_d   = round_sum_q;
    perm_err_d    = perm_err_q;
    round_count_d = round_count_q;
    if (reload_fire) begin
      acc_d         = '0;
      used_d        = '0;
      idx_d         = '0;
      err_d         = 1'b0;
      round_count_d = '0;
    end else if (probe_fire) begin
      if (idx_q == 3'd7) begin
        round_sum_d   = acc_q + {3'b000, Cost};
        perm_err_d    = err_q | probe_err;
        round_done_d  = 1'b1;
        round_count_d = (round_count_q == '1) ? round_count_q : round_count_q + 16'd1;
        acc_d         = '0;
        used_d        = '0;
        idx_d         = '0;
        err_d         = 1'b0;
      end else begin
        acc_d     = acc_q + {3'b000, Cost};
        used_d[J] = 1'b1;
        idx_d     = idx_q + 3'd1;
        err_d     = err_q | probe_err;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q         <= '0;
      used_q        <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      round_done_q  <= 1'b0;
      round_sum_q   <= '0;
      perm_err_q    <= 1'b0;
      round_count_q <= '0;
    end else begin
      acc_q         <= acc_d;
      used_q        <= used_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      round_done_q  <= round_done_d;
      round_sum_q   <= round_sum_d;
      perm_err_q    <= perm_err_d;
      round_count_q <= round_count_d;
    end
  end

  assign RoundDone  = round_done_q;
  assign RoundSum   = round_sum_q;
  assign PermErr    = perm_err_q;
  assign RoundCount = round_count_q;
`else
  logic unused_probe;
  assign unused_probe = Probe ^ reload_fire;
  assign RoundDone    = 1'b0;
  assign RoundSum     = '0;
  assign PermErr      = 1'b0;
  assign RoundCount   = '0;
`endif

endmodule

// File: tb/tb_cost_table_server.sv
// Randomized scoreboard bench for cost_table_server against a behavioural table/round model.
module tb_cost_table_server;
`ifdef COST_TABLE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ld_valid, reload, probe;
  logic [6:0]  ld_data;
  logic [2:0]  w, j;
  logic        LdReady, Loaded, RoundDone, PermErr;
  logic [6:0]  Cost;
  logic [9:0]  RoundSum;
  logic [15:0] RoundCount;

  always #5 clk = ~clk;

  cost_table_server dut (
    .CLK(clk), .RST(rst), .LdValid(ld_valid), .LdData(ld_data), .LdReady(LdReady),
    .Loaded(Loaded), .Reload(reload), .W(w), .J(j), .Cost(Cost), .Probe(probe),
    .RoundDone(RoundDone), .RoundSum(RoundSum), .PermErr(PermErr), .RoundCount(RoundCount)
  );

  typedef struct { int sum; int perm; int cnt; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err = 0;

  int mdl_tab [64];
  bit mdl_loaded;
  int mdl_ptr, mdl_count, mdl_sum, mdl_perm;
  int pw[$], pj[$], pc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_round();
    pw.delete(); pj.delete(); pc.delete();
  endtask

  task automatic model_edge();
    int s;
    bit bad;
    bit seen [8];
    if (rst) begin
      mdl_loaded = 0; mdl_ptr = 0; mdl_count = 0; mdl_sum = 0; mdl_perm = 0;
      clear_round();
    end else if (!mdl_loaded) begin
      if (ld_valid) begin
        mdl_tab[mdl_ptr] = int'(ld_data);
        mdl_ptr++;
        if (mdl_ptr == 64) mdl_loaded = 1;
      end
    end else if (reload) begin
      mdl_loaded = 0; mdl_ptr = 0; mdl_count = 0;
      clear_round();
    end else if (probe && CHK) begin
      pw.push_back(int'(w)); pj.push_back(int'(j));
      pc.push_back(mdl_tab[int'(w) * 8 + int'(j)]);
      if (pw.size() == 8) begin
        s = 0; bad = 0;
        for (int i = 0; i < 8; i++) seen[i] = 0;
        for (int i = 0; i < 8; i++) begin
          s += pc[i];
          if (pw[i] != i) bad = 1;
          if (seen[pj[i]]) bad = 1;
          seen[pj[i]] = 1;
        end
        mdl_sum = s; mdl_perm = int'(bad);
        if (mdl_count < 65535) mdl_count++;
        sb.push_back('{s, int'(bad), mdl_count});
        clear_round();
      end
    end
  endtask

  // Checks the current cycle's outputs, then advances one clock edge.
  task automatic tick();
    @(negedge clk);
    chk("cost", int'(Cost), mdl_loaded ? mdl_tab[int'(w) * 8 + int'(j)] : 0);
    chk("loaded", int'(Loaded), int'(mdl_loaded));
    chk("ld_ready", int'(LdReady), int'(!mdl_loaded));
    chk("round_count", int'(RoundCount), mdl_count);
    chk("round_sum", int'(RoundSum), mdl_sum);
    chk("perm_err", int'(PermErr), mdl_perm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(input string name, input int wi, input int ji, input int exp);
    w = 3'(wi); j = 3'(ji);
    #2;
    chk(name, int'(Cost), exp);
  endtask

  task automatic idle();
    ld_valid = 0; reload = 0; probe = 0; rst = 0;
    w = 3'($urandom_range(7)); j = 3'($urandom_range(7));
  endtask

  task automatic load_words(input int n, input bit ident, input bit gaps);
    int sent = 0;
    while (sent < n) begin
      idle();
      if (!gaps || (sent + mdl_ptr) % 2 == 0 || ($urandom_range(1) == 0)) begin
        ld_valid = 1;
        ld_data  = ident ? 7'(mdl_ptr) : 7'($urandom_range(127));
        sent++;
      end else begin
        ld_data = 7'($urandom_range(127));
      end
      tick();
    end
    idle();
  endtask

  // One round of 8 probes; kind 0 legal, 1 duplicate job, 2 wrong worker order.
  task automatic run_round(input int kind, input bit gaps);
    int perm [8];
    int k, t;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      k = $urandom_range(i); t = perm[i]; perm[i] = perm[k]; perm[k] = t;
    end
    k = $urandom_range(6);
    if (kind == 1) perm[k + 1] = perm[k];
    for (int i = 0; i < 8; i++) begin
      while (gaps && $urandom_range(2) == 0) begin idle(); tick(); end
      idle();
      probe = 1;
      w = 3'((kind == 2 && i == k) ? (i + 1) % 8 : i);
      j = 3'(perm[i]);
      tick();
    end
    idle();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && RoundDone === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL round_done_unexpected: got pulse expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_round_sum", int'(RoundSum), e.sum);
        chk("sb_perm_err", int'(PermErr), e.perm);
        chk("sb_round_count", int'(RoundCount), e.cnt);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    idle(); ld_data = '0; rst = 1;
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    idle(); tick();

    // Identity table loaded back-to-back.
    load_words(64, 1, 0);
    chk("loaded_after_64", int'(Loaded), 1);
    chk("ld_ready_after_64", int'(LdReady), 0);
    peek("cost_3_5", 3, 5, 29);
    peek("cost_7_7", 7, 7, 63);

    // Legal diagonal round, then duplicate-job round, then a legal round with gaps.
    for (int i = 0; i < 8; i++) begin
      idle(); probe = 1; w = 3'(i); j = 3'(i); tick();
    end
    idle(); tick();
    chk("diag_round_sum", int'(RoundSum), CHK ? 252 : 0);
    chk("diag_perm_err", int'(PermErr), 0);
    chk("diag_round_count", int'(RoundCount), CHK ? 1 : 0);
    for (int i = 0; i < 8; i++) begin
      idle(); probe = 1; w = 3'(i); j = 3'(i == 1 ? 0 : i); tick();
    end
    idle(); tick();
    chk("dup_round_sum", int'(RoundSum), CHK ? 251 : 0);
    chk("dup_perm_err", int'(PermErr), CHK ? 1 : 0);
    run_round(0, 1);
    idle(); tick();
    chk("legal_round_count", int'(RoundCount), CHK ? 3 : 0);
    chk("legal_perm_err", int'(PermErr), 0);
    for (int r = 0; r < 12; r++) run_round($urandom_range(2), $urandom_range(1) == 1);

    // Reload coincident with the 8th probe: reload wins, no round completes.
    for (int i = 0; i < 7; i++) begin
      idle(); probe = 1; w = 3'(i); j = 3'(i); tick();
    end
    idle(); probe = 1; reload = 1; w = 3'd7; j = 3'd7; tick();
    idle(); tick();
    chk("reload_loaded", int'(Loaded), 0);
    chk("reload_ld_ready", int'(LdReady), 1);
    chk("reload_round_count", int'(RoundCount), 0);
    peek("reload_cost_zero", 7, 7, 0);

    // Random table with LdValid gaps, then a stray word after completion.
    load_words(64, 0, 1);
    idle(); ld_valid = 1; ld_data = 7'($urandom_range(127)); tick();
    for (int k = 0; k < 64; k++) begin idle(); w = 3'(k / 8); j = 3'(k % 8); tick(); end
    for (int r = 0; r < 6; r++) run_round($urandom_range(2), 1);

    // Mid-load reset after 20 words: 44 more are not enough, 64 are.
    idle(); reload = 1; tick();
    load_words(20, 0, 0);
    idle(); rst = 1; tick();
    idle(); tick();
    chk("rst_ld_ready", int'(LdReady), 1);
    chk("rst_loaded", int'(Loaded), 0);
    load_words(44, 0, 0);
    chk("rst_44_not_loaded", int'(Loaded), 0);
    load_words(20, 0, 0);
    chk("rst_64_loaded", int'(Loaded), 1);
    for (int k = 0; k < 64; k++) begin idle(); w = 3'(k / 8); j = 3'(k % 8); tick(); end
    for (int r = 0; r < 6; r++) run_round($urandom_range(2), $urandom_range(1) == 1);

    idle(); tick(); tick();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
